// File: rtl/store_byte_rmw_pkg.sv
// Shared encodings for the store read-modify-write path: FSM states, lane ids and widths.
package store_byte_rmw_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned LANE_W  = 2;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned HALF_W  = 16;
    localparam int unsigned CNT_W   = 8;

    localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] S_RD   = 2'd1;
    localparam logic [STATE_W-1:0] S_WAIT = 2'd2;
    localparam logic [STATE_W-1:0] S_WR   = 2'd3;

    // Little-endian byte lanes, same numbering as word_to_byte.
    localparam logic [LANE_W-1:0] LANE0 = 2'd0;
    localparam logic [LANE_W-1:0] LANE1 = 2'd1;
    localparam logic [LANE_W-1:0] LANE2 = 2'd2;
    localparam logic [LANE_W-1:0] LANE3 = 2'd3;

endpackage

// File: rtl/store_byte_rmw_byte_merge.sv
// Replaces one byte lane (or one halfword when half=1, lane[1] picks the half)
// of a 32-bit word; the inverse of word_to_byte.
module store_byte_rmw_byte_merge
    import store_byte_rmw_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [HALF_W-1:0] data,
    input  logic [LANE_W-1:0] lane,
    input  logic              half,
    output logic [WORD_W-1:0] merged_c
);

    always_comb begin
        merged_c = word;
        if (half) begin
            if (lane[1]) begin
                merged_c[31:16] = data;
            end else begin
                merged_c[15:0] = data;
            end
        end else begin
            case (lane)
                LANE0:   merged_c[7:0]   = data[7:0];
                LANE1:   merged_c[15:8]  = data[7:0];
                LANE2:   merged_c[23:16] = data[7:0];
                LANE3:   merged_c[31:24] = data[7:0];
                default: merged_c        = word;
            endcase
        end
    end

endmodule

// File: rtl/store_byte_rmw.sv
// Store unit: sw as a single word write, sb (and sh when STORE_HALF_EN is defined)
// as read-modify-write of the aligned word, with a bounded wait for read data.
module store_byte_rmw
    import store_byte_rmw_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              storebyte,
`ifdef STORE_HALF_EN
    input  logic              storehalf,
`endif
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_we,
    output logic [31:0]       mem_wdata
);

    logic [STATE_W-1:0] state_q,     state_d;
    logic               busy_q,      busy_d;
    logic               err_q,       err_d;
    logic               re_q,        re_d;
    logic               we_q,        we_d;
    logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
    logic [WORD_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [HALF_W-1:0]  data_q,      data_d;
    logic [LANE_W-1:0]  lane_q,      lane_d;
    logic               half_q,      half_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;

    logic               half_req_c;
    logic [WORD_W-1:0]  merged_c;

`ifdef STORE_HALF_EN
    assign half_req_c = storehalf & ~storebyte;
`else
    assign half_req_c = 1'b0;
`endif

    store_byte_rmw_byte_merge u_merge (
        .word     (mem_rdata),
        .data     (data_q),
        .lane     (lane_q),
        .half     (half_q),
        .merged_c (merged_c)
    );

    // Next state; outputs are registered from the next state so they line up with it.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        data_d      = data_q;
        lane_d      = lane_q;
        half_d      = half_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
                    data_d     = wdata[15:0];
                    lane_d     = addr[1:0];
                    half_d     = half_req_c;
                    if (storebyte || half_req_c) begin
                        state_d = S_RD;
                    end else begin
                        mem_wdata_d = wdata;
                        state_d     = S_WR;
                    end
                end
            end
            S_RD: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Read data arriving on the limit cycle still wins over the timeout.
                if (mem_rvalid) begin
                    mem_wdata_d = merged_c;
                    state_d     = S_WR;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        re_d   = (state_d == S_RD);
        we_d   = (state_d == S_WR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            data_q      <= '0;
            lane_q      <= '0;
            half_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            re_q        <= re_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            data_q      <= data_d;
            lane_q      <= lane_d;
            half_q      <= half_d;
            cnt_q       <= cnt_d;
        end
    end

    assign busy      = busy_q;
    assign done      = we_q;
    assign err       = err_q;
    assign mem_re    = re_q;
    assign mem_we    = we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
